// File: rtl/mod_n_updown_counter_pkg.sv
// Shared definitions for the mod-N up/down counter: direction encodings and the
// width-agnostic clamp used by the load path (load path enabled by CNT_LOAD_EN).
package cnt_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Works on 32-bit values so any counter width can share it; callers cast back.
  function automatic int unsigned cnt_clamp(input int unsigned val,
                                            input int unsigned max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/mod_n_updown_counter_if.sv
// Control/status bundle of the mod-N up/down counter; the master drives the
// controls and observes count, z and wrap.
interface cnt_if #(
  parameter int WIDTH = 2
) ();

  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             z;
  logic             wrap;

  modport master (
    output en, up, load, load_val,
    input  count, z, wrap
  );

  modport slave (
    input  en, up, load, load_val,
    output count, z, wrap
  );

endinterface

// File: rtl/mod_n_updown_counter_next_state.sv
// Combinational next-count, Mealy terminal flag and wrap-event logic.
// The load path exists only when CNT_LOAD_EN is defined.
module cnt_next_state
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count_q,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count_d,
  output logic             wrap_d,
  output logic             z_raw
);

  localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic             load_eff;
  logic [WIDTH-1:0] load_clamped;
  logic             terminal;

`ifdef CNT_LOAD_EN
  assign load_eff     = load;
  assign load_clamped = WIDTH'(cnt_clamp(32'(load_val), 32'(MODULUS - 1)));
`else
  logic unused_load;
  assign unused_load  = ^{load, load_val};
  assign load_eff     = 1'b0;
  assign load_clamped = CNT_ZERO;
`endif

  assign terminal = (up == CNT_UP) ? (count_q == CNT_MAX) : (count_q == CNT_ZERO);

  // A load edge suppresses the flag because counting is not what happens next.
  assign z_raw = en & terminal & ~load_eff;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load_eff) begin
      count_d = load_clamped;
    end else if (en) begin
      if (terminal) begin
        if (SATURATE == 0) begin
          count_d = (up == CNT_UP) ? CNT_ZERO : CNT_MAX;
          wrap_d  = 1'b1;
        end
      end else if (up == CNT_UP) begin
        count_d = count_q + CNT_ONE;
      end else begin
        count_d = count_q - CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/mod_n_updown_counter.sv
// Mod-N up/down counter top: state registers and reset only.
// Define CNT_LOAD_EN to enable the synchronous load path.
module mod_n_updown_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 2,
  parameter int MODULUS  = 4,
  parameter int SATURATE = 0
) (
  input  logic  clk,
  input  logic  rst_n,
  cnt_if.slave  bus
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             z_raw;

  cnt_next_state #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next_state (
    .count_q  (count_q),
    .en       (bus.en),
    .up       (bus.up),
    .load     (bus.load),
    .load_val (bus.load_val),
    .count_d  (count_d),
    .wrap_d   (wrap_d),
    .z_raw    (z_raw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // z is combinational, so reset has to mask it explicitly.
  assign bus.z     = rst_n & z_raw;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;

endmodule

// File: doc/mod_n_updown_counter.md
MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

Interface
REQ-001 Parameter WIDTH, default 2, counter register width in bits; SHALL be at least 1.
REQ-002 Parameter MODULUS, default 4, count range 0..MODULUS-1; SHALL satisfy 2 <= MODULUS <= 2**WIDTH.
REQ-003 Parameter SATURATE, default 0; 0 = wrap at terminal, 1 = hold at terminal.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  count enable, sampled on the clk rising edge.
REQ-007 up  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 load  input  1  synchronous load strobe.
REQ-009 load_val  input  WIDTH  value to load.
REQ-010 count  output  WIDTH  registered current count.
REQ-011 z  output  1  combinational (Mealy) terminal-count flag.
REQ-012 wrap  output  1  registered one-cycle pulse after a wrap event.

Function
REQ-013 Priority on each edge SHALL be: load, then en, then hold.
REQ-014 With en=1, up=1 and count<MODULUS-1, count SHALL become count+1 on the next edge.
REQ-015 With en=1, up=0 and count>0, count SHALL become count-1 on the next edge.
REQ-016 Terminal condition SHALL be (up=1 and count=MODULUS-1) or (up=0 and count=0).
REQ-017 z SHALL equal en AND terminal condition, with no register delay; z SHALL be 0 when load=1.
REQ-018 SATURATE=0 at terminal with en=1: count SHALL wrap to 0 when counting up, or to MODULUS-1 when counting down.
REQ-019 SATURATE=0: wrap SHALL be 1 for exactly the cycle following a wrap edge, and 0 otherwise.
REQ-020 SATURATE=1 at terminal with en=1: count SHALL hold, z SHALL stay 1, and wrap SHALL stay 0.
REQ-021 A load edge SHALL set count to min(load_val, MODULUS-1) and SHALL clear wrap on the next cycle.
REQ-022 Changing up while en=1 SHALL take effect on the very next edge, with no dead cycle.
REQ-023 count SHALL never hold a value >= MODULUS.

Reset
REQ-024 With rst_n=0, count SHALL be 0 and wrap SHALL be 0 immediately, independent of clk.
REQ-025 With rst_n=0, z SHALL be forced to 0.
REQ-026 Counting SHALL resume on the first rising edge after rst_n deasserts.
REQ-027 Reset asserted mid-count SHALL discard any pending load or count action.

Configuration
REQ-028 Macro CNT_LOAD_EN defined: load and load_val SHALL behave per REQ-013 and REQ-021.
REQ-029 Macro CNT_LOAD_EN undefined: ports SHALL remain present, inputs SHALL be ignored, and no load logic SHALL be synthesised.

Structure
REQ-030 Shared package cnt_pkg SHALL hold the direction constants CNT_UP and CNT_DOWN.
REQ-031 cnt_pkg SHALL hold a WIDTH-agnostic clamp function used by the load path.
REQ-032 One sub-module, cnt_next_state, SHALL compute the next count and the terminal/wrap flags combinationally.
REQ-033 The top level SHALL hold only registers and reset.

Verification
REQ-034 WIDTH=2, MODULUS=4, up=1, en=1 for 5 edges -> count 0,1,2,3,0; z=1 only while count=3; wrap=1 in the cycle count=0 follows 3.
REQ-035 WIDTH=2, MODULUS=3, up=0 from count=0 -> count 2,1,0,2; z=1 while count=0.
REQ-036 SATURATE=1, MODULUS=4, up=1 for 6 edges -> count 0,1,2,3,3,3; wrap never asserts.
REQ-037 CNT_LOAD_EN defined, MODULUS=3, load=1 with load_val=3 -> count=2; load=1 together with en=1 -> load wins.
REQ-038 rst_n pulsed low at count=2 between clock edges -> count=0 and z=0 at once; count=1 on the first edge after release with en=1, up=1.
REQ-039 en toggling every 30 ns on a 10 ns clock -> count advances only during en-high windows; z never asserts while en=0.
